// File: rtl/lcd_pkg.sv
// Shared types, default timing and configuration contents for the LCD command sequencer.
package lcd_pkg;

    typedef enum logic [3:0] {
        WAIT_INIT,
        CFG_LOAD,
        SETUP_HI,
        E_HI,
        HOLD_HI,
        GAP,
        SETUP_LO,
        E_LO,
        HOLD_LO,
        EXEC_WAIT,
        IDLE
    } state_t;

    // Default timing in 50 MHz clk cycles.
    localparam int DEF_SETUP_CYC      = 2;
    localparam int DEF_E_PULSE_CYC    = 12;
    localparam int DEF_HOLD_CYC       = 1;
    localparam int DEF_NIBBLE_GAP_CYC = 50;
    localparam int DEF_CMD_WAIT_CYC   = 2000;
    localparam int DEF_CLEAR_WAIT_CYC = 82000;

    // Wide enough for the longest wait (Clear / Return Home).
    localparam int CNT_W = 17;

    // Post-init configuration: function set, entry mode, display on, clear.
    localparam int CFG_LEN = 4;
    localparam int IDX_W   = $clog2(CFG_LEN);
    localparam logic [CFG_LEN-1:0][7:0] CFG_ROM = {8'h01, 8'h0C, 8'h06, 8'h28};

    // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution wait.
    function automatic logic is_clear(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'b0);
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Decodes a sequencer state into the pin values and phase length for one nibble strobe.
// The same instance serves the upper (_HI) and lower (_LO) nibble of every byte.
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int E_PULSE_CYC = DEF_E_PULSE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
    input  state_t           state,
    input  logic [7:0]       data,
    input  logic             rs,
    output logic [3:0]       db,
    output logic             e,
    output logic             rs_pin,
    output logic [CNT_W-1:0] phase_cyc
);

    logic hi_phase;
    logic lo_phase;

    assign hi_phase = state inside {SETUP_HI, E_HI, HOLD_HI};
    assign lo_phase = state inside {SETUP_LO, E_LO, HOLD_LO};
    assign rs_pin   = (hi_phase || lo_phase) && rs;

    // Pin values and counter reload for the setup / strobe / hold phases.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        db        = 4'h0;
        e         = 1'b0;
        phase_cyc = '0;
        if (hi_phase) db = data[7:4];
        if (lo_phase) db = data[3:0];
        case (state)
            SETUP_HI, SETUP_LO: phase_cyc = CNT_W'(SETUP_CYC - 1);
            E_HI, E_LO: begin
                e         = 1'b1;
                phase_cyc = CNT_W'(E_PULSE_CYC - 1);
            end
            HOLD_HI, HOLD_LO:   phase_cyc = CNT_W'(HOLD_CYC - 1);
            default:            phase_cyc = '0;
        endcase
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Owns the 4-bit character LCD bus after power-on init: passes the init FSM through,
// then sends the configuration bytes and serves byte-write requests.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = DEF_SETUP_CYC,
    parameter int E_PULSE_CYC    = DEF_E_PULSE_CYC,
    parameter int HOLD_CYC       = DEF_HOLD_CYC,
    parameter int NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
    parameter int CMD_WAIT_CYC   = DEF_CMD_WAIT_CYC,
    parameter int CLEAR_WAIT_CYC = DEF_CLEAR_WAIT_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic [3:0] init_db,
    input  logic       init_e,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       cfg_done,
    output logic       busy,
    output logic [3:0] lcd_db,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             cfg_active, cfg_active_nxt;
    logic             cfg_done_nxt;
    logic             cur_rs, cur_rs_nxt;
    logic [7:0]       cur_data, cur_data_nxt;
    logic             cnt_zero;
    logic             pass_en;
    logic [3:0]       db_q;
    logic             e_q;
    logic             rs_q;
    logic [3:0]       strobe_db;
    logic             strobe_e;
    logic             strobe_rs;
    logic [CNT_W-1:0] strobe_cyc;

    assign cnt_zero = (cnt == '0);

    // Pin values for the state about to be entered, so the pins can be registered.
    lcd_nibble_strobe #(
        .SETUP_CYC  (SETUP_CYC),
        .E_PULSE_CYC(E_PULSE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) u_strobe (
        .state    (state_nxt),
        .data     (cur_data_nxt),
        .rs       (cur_rs_nxt),
        .db       (strobe_db),
        .e        (strobe_e),
        .rs_pin   (strobe_rs),
        .phase_cyc(strobe_cyc)
    );

    // Next state, configuration progress and byte latching.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cfg_active_nxt = cfg_active;
        cfg_done_nxt   = cfg_done;
        cur_rs_nxt     = cur_rs;
        cur_data_nxt   = cur_data;
        if (state != WAIT_INIT && !init_done) begin
            // Init FSM restarted: abandon everything and hand the bus back.
            state_nxt      = WAIT_INIT;
            idx_nxt        = '0;
            cfg_active_nxt = 1'b0;
            cfg_done_nxt   = 1'b0;
            cur_rs_nxt     = 1'b0;
            cur_data_nxt   = 8'h00;
        end else begin
            case (state)
                WAIT_INIT: if (init_done) begin
                    state_nxt      = CFG_LOAD;
                    idx_nxt        = '0;
                    cfg_active_nxt = 1'b1;
                end
                CFG_LOAD: begin
                    cur_data_nxt = CFG_ROM[idx];
                    cur_rs_nxt   = 1'b0;
                    state_nxt    = SETUP_HI;
                end
                SETUP_HI:  if (cnt_zero) state_nxt = E_HI;
                E_HI:      if (cnt_zero) state_nxt = HOLD_HI;
                HOLD_HI:   if (cnt_zero) state_nxt = GAP;
                GAP:       if (cnt_zero) state_nxt = SETUP_LO;
                SETUP_LO:  if (cnt_zero) state_nxt = E_LO;
                E_LO:      if (cnt_zero) state_nxt = HOLD_LO;
                HOLD_LO:   if (cnt_zero) state_nxt = EXEC_WAIT;
                EXEC_WAIT: if (cnt_zero) begin
                    if (!cfg_active) begin
                        state_nxt = IDLE;
                    end else if (idx == IDX_W'(CFG_LEN - 1)) begin
                        cfg_active_nxt = 1'b0;
                        cfg_done_nxt   = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = CFG_LOAD;
                    end
                end
                IDLE: if (req_valid) begin
                    cur_rs_nxt   = req_rs;
                    cur_data_nxt = req_data;
                    state_nxt    = SETUP_HI;
                end
                default: state_nxt = WAIT_INIT;
            endcase
        end
    end

    // Down-counter: reload with the new state's length on entry, otherwise count to 0.
    always_comb begin
        cnt_nxt = cnt_zero ? cnt : cnt - 1'b1;
        if (state_nxt != state) begin
            case (state_nxt)
                GAP:       cnt_nxt = CNT_W'(NIBBLE_GAP_CYC - 1);
                EXEC_WAIT: cnt_nxt = is_clear(cur_rs, cur_data) ? CNT_W'(CLEAR_WAIT_CYC - 1)
                                                                : CNT_W'(CMD_WAIT_CYC - 1);
                default:   cnt_nxt = strobe_cyc;
            endcase
        end
    end

    // State, counter and registered outputs.
    // NOTE: async reset drives every output register to its idle value, so the pins drop at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_INIT;
            cnt        <= '0;
            idx        <= '0;
            cfg_active <= 1'b0;
            cfg_done   <= 1'b0;
            cur_rs     <= 1'b0;
            cur_data   <= 8'h00;
            db_q       <= 4'h0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            pass_en    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            cfg_active <= cfg_active_nxt;
            cfg_done   <= cfg_done_nxt;
            cur_rs     <= cur_rs_nxt;
            cur_data   <= cur_data_nxt;
            db_q       <= strobe_db;
            e_q        <= strobe_e;
            rs_q       <= strobe_rs;
            req_ready  <= (state_nxt == IDLE);
            busy       <= (state_nxt != IDLE);
            pass_en    <= (state_nxt == WAIT_INIT);
        end
    end

    // The init FSM drives the pins directly while it owns the bus.
    assign lcd_db = pass_en ? init_db : db_q;
    assign lcd_e  = pass_en ? init_e  : e_q;
    assign lcd_rs = rs_q;
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: stimulus queues the expected nibbles,
// a monitor checks each lcd_e strobe against them. Execution waits are shortened.
module tb_lcd_cmd_sequencer;

    localparam int SETUP   = 2;
    localparam int E_PULSE = 12;
    localparam int HOLD    = 1;
    localparam int GAP_C   = 50;
    localparam int WN      = 200;
    localparam int WC      = 820;
    localparam int XFER    = 2 * (SETUP + E_PULSE + HOLD) + GAP_C;
    localparam int CFG_TOTAL = 2 + 3 * (XFER + WN + 1) + XFER + WC;
    localparam int BUDGET  = 5000;

    typedef struct packed {
        logic       rs;
        logic [3:0] nib;
    } nib_t;

    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [31:0] wt;
    } req_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_done;
    logic [3:0] init_db;
    logic       init_e;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       cfg_done;
    logic       busy;
    logic [3:0] lcd_db;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    bit   mon_en = 1'b0;
    nib_t exp_q[$];

    req_vec_t vecs[5] = '{
        '{1'b1, 8'h41, WN},
        '{1'b0, 8'h01, WC},
        '{1'b1, 8'h01, WN},
        '{1'b0, 8'h03, WC},
        '{1'b0, 8'h04, WN}
    };

    lcd_cmd_sequencer #(
        .CMD_WAIT_CYC  (WN),
        .CLEAR_WAIT_CYC(WC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .init_done(init_done),
        .init_db  (init_db),
        .init_e   (init_e),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .cfg_done (cfg_done),
        .busy     (busy),
        .lcd_db   (lcd_db),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (req_valid && req_ready) n_acc <= n_acc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] data);
        exp_q.push_back({rs, data[7:4]});
        exp_q.push_back({rs, data[3:0]});
    endtask

    task automatic push_config();
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic wait_ready();
        int b;
        b = 0;
        while (!req_ready && b < BUDGET) begin
            @(negedge clk);
            b++;
        end
        check("req_ready_wait", req_ready, 1);
    endtask

    task automatic wait_config(input int c0);
        int b;
        b = 0;
        while (!cfg_done && b < 3 * BUDGET) begin
            @(negedge clk);
            b++;
        end
        check("cfg_done_latency", cyc - c0, CFG_TOTAL);
        check("cfg_ready", req_ready, 1);
        check("cfg_busy", busy, 0);
        check("cfg_queue_drained", exp_q.size(), 0);
    endtask

    // Issue one request from a negedge; returns the cycle count seen after the accept edge.
    task automatic start_req(input logic rs, input logic [7:0] data, output int acc_cyc);
        wait_ready();
        push_byte(rs, data);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        @(negedge clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        check("first_nibble_db", lcd_db, data[7:4]);
        check("first_nibble_e", lcd_e, 0);
        check("first_nibble_rs", lcd_rs, rs);
        check("ready_drop", req_ready, 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] data, input int wait_cyc);
        int a;
        int b;
        start_req(rs, data, a);
        b = 0;
        while (!req_ready && b < BUDGET) begin
            @(negedge clk);
            b++;
        end
        check("ready_latency", cyc - a, XFER + wait_cyc);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: every lcd_e pulse must match the next queued nibble, last E_PULSE cycles
    // with stable data, and keep the nibble for the hold cycle.
    initial begin : monitor
        logic e_prev;
        logic active;
        logic stable;
        int   hi_len;
        nib_t cur;
        e_prev = 1'b0;
        active = 1'b0;
        stable = 1'b1;
        hi_len = 0;
        cur    = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                e_prev = 1'b0;
                active = 1'b0;
            end else begin
                if (lcd_e && !e_prev) begin
                    check("strobe_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check("strobe_db", lcd_db, cur.nib);
                        check("strobe_rs", lcd_rs, cur.rs);
                    end
                    active = 1'b1;
                    stable = 1'b1;
                    hi_len = 1;
                end else if (lcd_e && active) begin
                    hi_len++;
                    if (lcd_db !== cur.nib || lcd_rs !== cur.rs) stable = 1'b0;
                end else if (!lcd_e && e_prev && active) begin
                    check("e_width", hi_len, E_PULSE);
                    check("e_stable", stable, 1);
                    check("hold_db", lcd_db, cur.nib);
                    active = 1'b0;
                end
                e_prev = lcd_e;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [4:0] pt_vec [4];
        int c0;
        int a;
        int a1;
        int a2;
        int n0;
        int b;

        pt_vec = '{5'h15, 5'h0A, 5'h07, 5'h18};

        reset     = 1'b1;
        init_done = 1'b0;
        init_db   = 4'hA;
        init_e    = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;

        // Reset values while the init FSM is already driving its pins.
        repeat (3) @(negedge clk);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_db", lcd_db, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_busy", busy, 1);

        // Pass-through while init_done is low.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            init_db = pt_vec[i][4:1];
            init_e  = pt_vec[i][0];
            #1;
            check("pass_db", lcd_db, pt_vec[i][4:1]);
            check("pass_e", lcd_e, pt_vec[i][0]);
            @(negedge clk);
        end
        check("pass_req_ready", req_ready, 0);

        // Configuration sequence.
        init_e  = 1'b0;
        init_db = 4'h0;
        push_config();
        mon_en    = 1'b1;
        init_done = 1'b1;
        c0 = cyc;
        wait_config(c0);

        // Directed byte writes with their expected execution waits.
        for (int i = 0; i < 5; i++) send(vecs[i].rs, vecs[i].data, int'(vecs[i].wt));

        // req_valid held high across two transfers: one accept per IDLE entry.
        wait_ready();
        n0 = n_acc;
        push_byte(1'b1, 8'h5A);
        push_byte(1'b1, 8'hC3);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        @(negedge clk);
        a1 = cyc;
        req_data = 8'hC3;
        check("held_first_accept", req_ready, 0);
        b = 0;
        while (!req_ready && b < BUDGET) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        a2 = cyc;
        req_valid = 1'b0;
        check("held_reaccept_gap", a2 - a1, XFER + WN + 1);
        wait_ready();
        check("held_accepts", n_acc - n0, 2);
        check("held_queue_drained", exp_q.size(), 0);

        // Reset during the lower-nibble strobe.
        start_req(1'b1, 8'h37, a);
        while (cyc < a + XFER - HOLD - E_PULSE + 3) @(negedge clk);
        check("lo_strobe_e", lcd_e, 1);
        check("lo_strobe_db", lcd_db, 4'h7);
        mon_en = 1'b0;
        exp_q.delete();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_lcd_e", lcd_e, 0);
        check("midrst_lcd_db", lcd_db, 0);
        check("midrst_lcd_rs", lcd_rs, 0);
        check("midrst_busy", busy, 1);
        check("midrst_cfg_done", cfg_done, 0);
        repeat (2) @(negedge clk);
        push_config();
        mon_en = 1'b1;
        reset  = 1'b0;
        c0 = cyc;
        wait_config(c0);

        // init_done falling mid-transfer returns the bus to the init FSM.
        check("cfg_done_before_abort", cfg_done, 1);
        start_req(1'b1, 8'h48, a);
        while (cyc < a + 20) @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        init_done = 1'b0;
        init_e    = 1'b1;
        init_db   = 4'h9;
        @(negedge clk);
        check("abort_cfg_done", cfg_done, 0);
        check("abort_busy", busy, 1);
        check("abort_req_ready", req_ready, 0);
        check("abort_pass_e", lcd_e, 1);
        check("abort_pass_db", lcd_db, 4'h9);
        check("abort_rs", lcd_rs, 0);
        init_e = 1'b0;
        #1;
        check("abort_pass_e_low", lcd_e, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
